// File: rtl/register_file_pkg.sv
// Shared defaults for the register file: data width, address width, register count.
package register_file_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 2 ** DEF_ADDR_W;

endpackage : register_file_pkg

// File: rtl/regfile_read_mux.sv
// One combinational read port: selects a register from the flattened bank,
// forces register 0 to zero and, with REGFILE_BYPASS_EN defined, forwards
// same-cycle write data when the addresses match.
module regfile_read_mux
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] regBank,
  input  logic [ADDR_W-1:0]             regNum,
`ifdef REGFILE_BYPASS_EN
  input  logic                          bypassEn,
  input  logic [ADDR_W-1:0]             bypassNum,
  input  logic [DATA_W-1:0]             bypassData,
`endif
  output logic [DATA_W-1:0]             readData
);

  // Select stored word, optionally override with in-flight write, then pin r0 to zero.
  always_comb begin
    readData = regBank[regNum*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
    if (bypassEn && (bypassNum == regNum)) begin
      readData = bypassData;
    end
`endif
    if (regNum == '0) begin
      readData = '0;
    end
  end

endmodule : regfile_read_mux

// File: rtl/register_file.sv
// Two-read / one-write register file with synchronous active-high reset.
// Register 0 is hardwired to zero. Define REGFILE_BYPASS_EN to forward
// write data to a matching read port within the same cycle.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] regNum1,
  input  logic [ADDR_W-1:0] regNum2,
  input  logic [ADDR_W-1:0] regWriteNum,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_W;

  // Flattened storage; slot 0 is never written so it stays at its reset value.
  logic [NUM_WORDS*DATA_W-1:0] regBank;

  // Reset clears everything and wins over a same-edge write; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      regBank <= '0;
    end else if (regWrite && (regWriteNum != '0)) begin
      regBank[regWriteNum*DATA_W +: DATA_W] <= writeData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic bypassEn;

  // A write is forwardable only when it will actually land at the next edge.
  always_comb begin
    bypassEn = regWrite && !reset && (regWriteNum != '0);
  end
`endif

  regfile_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_readPort1 (
    .regBank    (regBank),
    .regNum     (regNum1),
`ifdef REGFILE_BYPASS_EN
    .bypassEn   (bypassEn),
    .bypassNum  (regWriteNum),
    .bypassData (writeData),
`endif
    .readData   (readData1)
  );

  regfile_read_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_readPort2 (
    .regBank    (regBank),
    .regNum     (regNum2),
`ifdef REGFILE_BYPASS_EN
    .bypassEn   (bypassEn),
    .bypassNum  (regWriteNum),
    .bypassData (writeData),
`endif
    .readData   (readData2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a driver applies one transaction per
// cycle and queues the expected read values from an array model; a monitor
// on the falling edge pops and compares against both read ports.
module tb_register_file;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
    bit            chk;
    string         name;
  } expect_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          regWrite;
  logic [AW-1:0] regNum1;
  logic [AW-1:0] regNum2;
  logic [AW-1:0] regWriteNum;
  logic [DW-1:0] writeData;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;

  int checks   = 0;
  int failures = 0;

  expect_t       sb[$];
  logic [DW-1:0] mdl [NR];
  bit            mdlKnown = 1'b0;

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .regWrite    (regWrite),
    .regNum1     (regNum1),
    .regNum2     (regNum2),
    .regWriteNum (regWriteNum),
    .writeData   (writeData),
    .readData1   (readData1),
    .readData2   (readData2)
  );

  always #5 clk = ~clk;

  // Expected read of one port given the model and the inputs of this cycle.
  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a, input bit rst,
                                            input bit we, input logic [AW-1:0] wn,
                                            input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (BYPASS && we && !rst && wn == a) return wd;
    return mdl[a];
  endfunction

  // Drive one cycle of inputs, queue the expected pre-edge reads, then advance the model.
  task automatic drive(input bit rst, input bit we, input logic [AW-1:0] wn,
                       input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input string nm);
    expect_t e;
    @(posedge clk);
    #1;
    reset = rst; regWrite = we; regWriteNum = wn; writeData = wd;
    regNum1 = a1; regNum2 = a2;
    e.exp1 = expRead(a1, rst, we, wn, wd);
    e.exp2 = expRead(a2, rst, we, wn, wd);
    e.chk  = mdlKnown;
    e.name = nm;
    sb.push_back(e);
    if (rst) begin
      foreach (mdl[i]) mdl[i] = '0;
      mdlKnown = 1'b1;
    end else if (we && wn != 0) begin
      mdl[wn] = wd;
    end
  endtask

  // Monitor: reads are combinational, so compare mid-cycle whenever a transaction is pending.
  always @(negedge clk) begin
    expect_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        checks = checks + 1;
        if (readData1 !== e.exp1) begin
          failures = failures + 1;
          $display("FAIL %s port1: got %h expected %h (addr %0d)", e.name, readData1, e.exp1, regNum1);
        end
        checks = checks + 1;
        if (readData2 !== e.exp2) begin
          failures = failures + 1;
          $display("FAIL %s port2: got %h expected %h (addr %0d)", e.name, readData2, e.exp2, regNum2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; regWrite = 1'b0; regNum1 = '0; regNum2 = '0;
    regWriteNum = '0; writeData = '0;
    foreach (mdl[i]) mdl[i] = '0;

    // Reset, then read every address on both ports.
    drive(1, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < NR; i++) drive(0, 0, 0, 0, AW'(i), AW'(NR - 1 - i), "reset_read");

    // Write 20 to r4 while reading it; persists across further edges.
    drive(0, 1, 4, 16'd20, 4, 0, "write_r4");
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 4, 0, "hold_r4");

    // Writes to r0 are ignored.
    drive(0, 1, 0, 16'hFFFF, 0, 0, "write_r0");
    drive(0, 0, 0, 0, 0, 0, "read_r0");

    // Write disable leaves r5 alone.
    drive(0, 1, 5, 16'h00AA, 5, 5, "set_r5");
    drive(0, 0, 5, 16'h1234, 5, 5, "nowrite_r5");
    drive(0, 0, 0, 0, 5, 5, "read_r5");

    // Reset beats a same-edge write.
    drive(0, 1, 3, 16'h0033, 3, 4, "set_r3");
    drive(1, 1, 3, 16'd7, 3, 4, "reset_vs_write");
    drive(0, 0, 0, 0, 3, 4, "read_r3");

    // Fill r1..r7 with 0x11*n and sweep both ports independently.
    for (int n = 1; n < NR; n++) drive(0, 1, AW'(n), DW'(16'h11 * n), AW'(n), 0, "fill");
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NR; j++) drive(0, 0, 0, 0, AW'(i), AW'(j), "dual_sweep");

    // Last write wins, repeated writes are idempotent.
    drive(0, 1, 6, 16'hBEEF, 6, 6, "ww1");
    drive(0, 1, 6, 16'hCAFE, 6, 6, "ww2");
    drive(0, 1, 6, 16'hCAFE, 6, 6, "ww3");
    drive(0, 0, 0, 0, 6, 6, "ww_read");

    // Randomised traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
            AW'($urandom_range(0, NR - 1)), DW'($urandom),
            AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)), "random");
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 16, width of each register and data port.
REQ-002 Parameter ADDR_W, default 3, register address width; register count is 2**ADDR_W (8).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 regWrite  input  1  write enable, sampled at clk rising edge.
REQ-007 regNum1  input  ADDR_W  read port 1 address.
REQ-008 regNum2  input  ADDR_W  read port 2 address.
REQ-009 regWriteNum  input  ADDR_W  write port address.
REQ-010 writeData  input  DATA_W  write port data.
REQ-011 readData1  output  DATA_W  contents of register regNum1.
REQ-012 readData2  output  DATA_W  contents of register regNum2.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits, indexed 0..2**ADDR_W-1.
REQ-014 Register 0 SHALL read as zero at all times; writes to address 0 SHALL be ignored.
REQ-015 At a clk rising edge with reset=0 and regWrite=1, register regWriteNum SHALL take writeData; all other registers hold.
REQ-016 With regWrite=0, no register SHALL change.
REQ-017 Reads SHALL be combinational (zero latency) from the current contents; a write becomes visible on read ports immediately after the capturing edge.
REQ-018 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-019 Addresses SHALL be fully decoded; no out-of-range case exists.
REQ-020 Repeated writes of the same value SHALL be idempotent; the last write to an address wins.

Reset
REQ-021 At a clk rising edge with reset=1, all registers SHALL clear to 0; readData1/readData2 then read 0.
REQ-022 reset SHALL have priority over regWrite on the same edge; the write is discarded.
REQ-023 reset SHALL have no effect between clock edges; contents persist until the next edge.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN: when defined, a read port whose address equals regWriteNum while regWrite=1, reset=0 and regWriteNum!=0 SHALL return writeData combinationally (write-through forwarding).
REQ-025 Without REGFILE_BYPASS_EN, read ports SHALL return only the stored contents; new data is visible after the edge.

Structure
REQ-026 Package register_file_pkg SHALL hold the DATA_W/ADDR_W defaults and the NUM_REGS constant.
REQ-027 One sub-module, regfile_read_mux, SHALL implement a single read port (address decode, zero-register forcing, optional bypass), instantiated twice.

Verification
REQ-028 Reset: assert reset one edge, then read all 8 addresses on both ports -> all 0.
REQ-029 Write/read: regWrite=1, regWriteNum=4, writeData=20, regNum1=4, regNum2=0 -> readData1=20 after the first rising edge (before it, 0 without bypass or 20 with bypass); readData2=0 throughout; value stays 20 over further edges.
REQ-030 Zero register: write 0xFFFF to address 0 -> readData1/readData2 at address 0 remain 0.
REQ-031 Write disable: regWrite=0, writeData=0x1234, regWriteNum=5 -> register 5 unchanged.
REQ-032 Reset priority: reset=1 and regWrite=1 (addr 3, data 7) on the same edge -> register 3 reads 0.
REQ-033 Dual port: fill registers 1..7 with 0x11*n, sweep regNum1 and regNum2 independently -> each port returns the matching value.
